lcd_text_buffer: RTL and testbench

Character store that sits directly upstream of the 12864 LCD controller and supplies the byte written at each of its 64 character positions (4 rows × 16 columns). Game/UI logic writes characters through a valid/ready port. The LCD stage reads combinationally by character index and pulses a frame boundary. Optional double buffering keeps partial updates off the panel until the host commits them.

---
 rtl/lcd_text_buffer.sv | 114 +++++++++++
 tb/tb_lcd_text_buffer.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_text_buffer.sv
// rtl/lcd_text_buffer.sv - 64-char LCD text store with host write port, clear engine and optional double buffer (LCD_TEXTBUF_DOUBLE_EN)
module lcd_text_buffer #(
  parameter logic [7:0] FILL_CHAR = 8'h20
) (
  input  logic       clk_10Hz,
  input  logic       rst_n,
  input  logic       wr_valid,
  output logic       wr_ready,
  input  logic       wr_inc,
  input  logic [5:0] wr_addr,
  input  logic [7:0] wr_data,
  input  logic       clr_req,
  input  logic       commit,
  input  logic       frame_sync,
  input  logic [5:0] rd_addr,
  output logic [7:0] rd_data,
  output logic       busy,
  output logic       swap_pending,
  output logic [5:0] cursor
);

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

  state_t     state;
  state_t     state_nxt;
  logic [5:0] clr_cnt;
  logic [7:0] wbank [64];
  logic       wr_fire;
  logic [5:0] wr_index;
  logic       clr_last;

  assign busy     = (state == CLEAR);
  assign wr_ready = (state == IDLE) && !clr_req;
  assign wr_fire  = wr_valid && wr_ready;
  assign wr_index = wr_inc ? cursor : wr_addr;
  assign clr_last = busy && (clr_cnt == 6'd63);

  // State register
  always_ff @(posedge clk_10Hz or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next state: clear wins over a same-cycle write and cannot be restarted
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (clr_req) state_nxt = CLEAR;
      CLEAR:   if (clr_cnt == 6'd63) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Clear sweep index, walks 0..63 while clearing and rests at 0
  always_ff @(posedge clk_10Hz or negedge rst_n) begin
    if (!rst_n)    clr_cnt <= 6'd0;
    else if (busy) clr_cnt <= clr_cnt + 6'd1;
    else           clr_cnt <= 6'd0;
  end

  // Cursor follows the last written index, homed when a clear completes
  always_ff @(posedge clk_10Hz or negedge rst_n) begin
    if (!rst_n)       cursor <= 6'd0;
    else if (clr_last) cursor <= 6'd0;
    else if (wr_fire) cursor <= wr_index + 6'd1;
  end

  // Write bank: clear sweep or host write
  always_ff @(posedge clk_10Hz or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 64; i++) wbank[i] <= FILL_CHAR;
    end else if (busy) begin
      wbank[clr_cnt] <= FILL_CHAR;
    end else if (wr_fire) begin
      wbank[wr_index] <= wr_data;
    end
  end

`ifdef LCD_TEXTBUF_DOUBLE_EN
  logic [7:0] dbank [64];
  logic       swap;

  // Publish only at a frame boundary and never in the middle of a clear
  assign swap = swap_pending && frame_sync && (state == IDLE);

  // Pending commit flag; a commit on the swap edge re-arms it
  always_ff @(posedge clk_10Hz or negedge rst_n) begin
    if (!rst_n)      swap_pending <= 1'b0;
    else if (commit) swap_pending <= 1'b1;
    else if (swap)   swap_pending <= 1'b0;
  end

  // Display bank: whole-screen copy of the pre-write write bank
  always_ff @(posedge clk_10Hz or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 64; i++) dbank[i] <= FILL_CHAR;
    end else if (swap) begin
      dbank <= wbank;
    end
  end

  assign rd_data = dbank[rd_addr];
`else
  logic unused_swap_inputs;

  assign unused_swap_inputs = commit ^ frame_sync;
  assign swap_pending       = 1'b0;
  assign rd_data            = wbank[rd_addr];
`endif

endmodule

// File: tb/tb_lcd_text_buffer.sv
// tb/tb_lcd_text_buffer.sv - directed self-checking bench for lcd_text_buffer
module tb_lcd_text_buffer;

  logic       clk_10Hz;
  logic       rst_n;
  logic       wr_valid;
  logic       wr_ready;
  logic       wr_inc;
  logic [5:0] wr_addr;
  logic [7:0] wr_data;
  logic       clr_req;
  logic       commit;
  logic       frame_sync;
  logic [5:0] rd_addr;
  logic [7:0] rd_data;
  logic       busy;
  logic       swap_pending;
  logic [5:0] cursor;

  int errors = 0;
  int checks = 0;

  lcd_text_buffer #(.FILL_CHAR(8'h20)) dut (
    .clk_10Hz     (clk_10Hz),
    .rst_n        (rst_n),
    .wr_valid     (wr_valid),
    .wr_ready     (wr_ready),
    .wr_inc       (wr_inc),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .clr_req      (clr_req),
    .commit       (commit),
    .frame_sync   (frame_sync),
    .rd_addr      (rd_addr),
    .rd_data      (rd_data),
    .busy         (busy),
    .swap_pending (swap_pending),
    .cursor       (cursor)
  );

  initial clk_10Hz = 1'b0;
  always #5 clk_10Hz = ~clk_10Hz;

  task automatic tick();
    @(posedge clk_10Hz);
    #1;
  endtask

  task automatic peek(input logic [5:0] a);
    rd_addr = a;
    #1;
  endtask

  task automatic do_write(input logic inc, input logic [5:0] a, input logic [7:0] d);
    wr_valid = 1'b1;
    wr_inc   = inc;
    wr_addr  = a;
    wr_data  = d;
    tick();
    wr_valid = 1'b0;
    wr_inc   = 1'b0;
  endtask

  task automatic publish();
`ifdef LCD_TEXTBUF_DOUBLE_EN
    commit = 1'b1;
    tick();
    commit = 1'b0;
    frame_sync = 1'b1;
    tick();
    frame_sync = 1'b0;
`endif
  endtask

  task automatic test_reset();
    rst_n = 1'b0; wr_valid = 1'b0; wr_inc = 1'b0; wr_addr = 6'd0; wr_data = 8'h00;
    clr_req = 1'b0; commit = 1'b0; frame_sync = 1'b0; rd_addr = 6'd0;
    repeat (2) tick();
    rst_n = 1'b1;
    #1;
    peek(6'd0);
    checks++; if (rd_data !== 8'h20) begin errors++; $display("FAIL reset_rd0: got %h expected 20", rd_data); end
    peek(6'd17);
    checks++; if (rd_data !== 8'h20) begin errors++; $display("FAIL reset_rd17: got %h expected 20", rd_data); end
    peek(6'd63);
    checks++; if (rd_data !== 8'h20) begin errors++; $display("FAIL reset_rd63: got %h expected 20", rd_data); end
    checks++; if (cursor !== 6'd0) begin errors++; $display("FAIL reset_cursor: got %0d expected 0", cursor); end
    checks++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL reset_wr_ready: got %b expected 1", wr_ready); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (swap_pending !== 1'b0) begin errors++; $display("FAIL reset_pending: got %b expected 0", swap_pending); end
  endtask

  task automatic test_wrap();
    do_write(1'b0, 6'd63, 8'h41);
    checks++; if (cursor !== 6'd0) begin errors++; $display("FAIL wrap_cursor0: got %0d expected 0", cursor); end
    do_write(1'b1, 6'd9, 8'h42);
    checks++; if (cursor !== 6'd1) begin errors++; $display("FAIL wrap_cursor1: got %0d expected 1", cursor); end
    publish();
    peek(6'd0);
    checks++; if (rd_data !== 8'h42) begin errors++; $display("FAIL wrap_rd0: got %h expected 42", rd_data); end
    peek(6'd63);
    checks++; if (rd_data !== 8'h41) begin errors++; $display("FAIL wrap_rd63: got %h expected 41", rd_data); end
    peek(6'd9);
    checks++; if (rd_data !== 8'h20) begin errors++; $display("FAIL wrap_rd9: got %h expected 20", rd_data); end
  endtask

  task automatic test_clear();
    int cnt;
    repeat (64) do_write(1'b1, 6'd0, 8'h11);
    publish();
    peek(6'd0);
    checks++; if (rd_data !== 8'h11) begin errors++; $display("FAIL fill_rd0: got %h expected 11", rd_data); end
    peek(6'd63);
    checks++; if (rd_data !== 8'h11) begin errors++; $display("FAIL fill_rd63: got %h expected 11", rd_data); end
    clr_req = 1'b1; wr_valid = 1'b1; wr_inc = 1'b0; wr_addr = 6'd7; wr_data = 8'h99;
    #1;
    checks++; if (wr_ready !== 1'b0) begin errors++; $display("FAIL clr_req_ready: got %b expected 0", wr_ready); end
    tick();
    clr_req = 1'b0; wr_valid = 1'b0;
    cnt = 0;
    while (busy === 1'b1 && cnt < 200) begin
      if (cnt == 10) begin
        checks++; if (wr_ready !== 1'b0) begin errors++; $display("FAIL clear_ready: got %b expected 0", wr_ready); end
        peek(6'd0);
`ifdef LCD_TEXTBUF_DOUBLE_EN
        checks++; if (rd_data !== 8'h11) begin errors++; $display("FAIL clear_mid_rd0: got %h expected 11", rd_data); end
`else
        checks++; if (rd_data !== 8'h20) begin errors++; $display("FAIL clear_mid_rd0: got %h expected 20", rd_data); end
`endif
        peek(6'd63);
        checks++; if (rd_data !== 8'h11) begin errors++; $display("FAIL clear_mid_rd63: got %h expected 11", rd_data); end
      end
      cnt++;
      tick();
    end
    checks++; if (cnt !== 64) begin errors++; $display("FAIL clear_busy_len: got %0d expected 64", cnt); end
    checks++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL clear_done_ready: got %b expected 1", wr_ready); end
    checks++; if (cursor !== 6'd0) begin errors++; $display("FAIL clear_cursor: got %0d expected 0", cursor); end
    publish();
    for (int i = 0; i < 64; i++) begin
      peek(i[5:0]);
      checks++; if (rd_data !== 8'h20) begin errors++; $display("FAIL clear_rd%0d: got %h expected 20", i, rd_data); end
    end
  endtask

`ifdef LCD_TEXTBUF_DOUBLE_EN
  task automatic test_double();
    do_write(1'b0, 6'd5, 8'h10);
    peek(6'd5);
    checks++; if (rd_data !== 8'h20) begin errors++; $display("FAIL dbl_hidden: got %h expected 20", rd_data); end
    commit = 1'b1;
    tick();
    commit = 1'b0;
    checks++; if (swap_pending !== 1'b1) begin errors++; $display("FAIL dbl_pending: got %b expected 1", swap_pending); end
    tick();
    tick();
    frame_sync = 1'b1;
    tick();
    frame_sync = 1'b0;
    peek(6'd5);
    checks++; if (rd_data !== 8'h10) begin errors++; $display("FAIL dbl_swap_rd5: got %h expected 10", rd_data); end
    checks++; if (swap_pending !== 1'b0) begin errors++; $display("FAIL dbl_swap_pending: got %b expected 0", swap_pending); end
    do_write(1'b0, 6'd6, 8'h66);
    commit = 1'b1; frame_sync = 1'b1;
    tick();
    commit = 1'b0; frame_sync = 1'b0;
    peek(6'd6);
    checks++; if (rd_data !== 8'h20) begin errors++; $display("FAIL dbl_same_edge_rd6: got %h expected 20", rd_data); end
    checks++; if (swap_pending !== 1'b1) begin errors++; $display("FAIL dbl_same_edge_pending: got %b expected 1", swap_pending); end
    do_write(1'b0, 6'd7, 8'h77);
    commit = 1'b1; frame_sync = 1'b1;
    wr_valid = 1'b1; wr_addr = 6'd8; wr_data = 8'h88;
    tick();
    commit = 1'b0; frame_sync = 1'b0; wr_valid = 1'b0;
    peek(6'd6);
    checks++; if (rd_data !== 8'h66) begin errors++; $display("FAIL dbl_rearm_rd6: got %h expected 66", rd_data); end
    peek(6'd8);
    checks++; if (rd_data !== 8'h20) begin errors++; $display("FAIL dbl_write_on_swap_rd8: got %h expected 20", rd_data); end
    checks++; if (swap_pending !== 1'b1) begin errors++; $display("FAIL dbl_rearm_pending: got %b expected 1", swap_pending); end
    frame_sync = 1'b1;
    tick();
    frame_sync = 1'b0;
    peek(6'd8);
    checks++; if (rd_data !== 8'h88) begin errors++; $display("FAIL dbl_next_swap_rd8: got %h expected 88", rd_data); end
  endtask

  task automatic test_deferred();
    int cnt;
    commit = 1'b1;
    tick();
    commit = 1'b0;
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    repeat (5) tick();
    frame_sync = 1'b1;
    tick();
    frame_sync = 1'b0;
    checks++; if (swap_pending !== 1'b1) begin errors++; $display("FAIL defer_pending: got %b expected 1", swap_pending); end
    peek(6'd5);
    checks++; if (rd_data !== 8'h10) begin errors++; $display("FAIL defer_rd5: got %h expected 10", rd_data); end
    cnt = 0;
    while (busy === 1'b1 && cnt < 200) begin
      cnt++;
      tick();
    end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL defer_clear_timeout: got busy %b expected 0", busy); end
    frame_sync = 1'b1;
    tick();
    frame_sync = 1'b0;
    checks++; if (swap_pending !== 1'b0) begin errors++; $display("FAIL defer_done_pending: got %b expected 0", swap_pending); end
    peek(6'd5);
    checks++; if (rd_data !== 8'h20) begin errors++; $display("FAIL defer_rd5_after: got %h expected 20", rd_data); end
    peek(6'd8);
    checks++; if (rd_data !== 8'h20) begin errors++; $display("FAIL defer_rd8_after: got %h expected 20", rd_data); end
  endtask
`else
  task automatic test_single();
    commit = 1'b1; frame_sync = 1'b1;
    tick();
    commit = 1'b0; frame_sync = 1'b0;
    checks++; if (swap_pending !== 1'b0) begin errors++; $display("FAIL single_pending: got %b expected 0", swap_pending); end
    do_write(1'b0, 6'd5, 8'h10);
    peek(6'd5);
    checks++; if (rd_data !== 8'h10) begin errors++; $display("FAIL single_latency_rd5: got %h expected 10", rd_data); end
    checks++; if (cursor !== 6'd6) begin errors++; $display("FAIL single_cursor: got %0d expected 6", cursor); end
  endtask
`endif

  task automatic test_reset_mid_clear();
    do_write(1'b0, 6'd3, 8'h55);
    do_write(1'b0, 6'd40, 8'h56);
    publish();
`ifdef LCD_TEXTBUF_DOUBLE_EN
    commit = 1'b1;
    tick();
    commit = 1'b0;
`endif
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    repeat (30) tick();
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL midclr_busy_before: got %b expected 1", busy); end
    peek(6'd40);
    checks++; if (rd_data !== 8'h56) begin errors++; $display("FAIL midclr_rd40_before: got %h expected 56", rd_data); end
    rst_n = 1'b0;
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midclr_busy: got %b expected 0", busy); end
    checks++; if (cursor !== 6'd0) begin errors++; $display("FAIL midclr_cursor: got %0d expected 0", cursor); end
    checks++; if (swap_pending !== 1'b0) begin errors++; $display("FAIL midclr_pending: got %b expected 0", swap_pending); end
    peek(6'd40);
    checks++; if (rd_data !== 8'h20) begin errors++; $display("FAIL midclr_rd40: got %h expected 20", rd_data); end
    tick();
    rst_n = 1'b1;
    #1;
    checks++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL midclr_ready: got %b expected 1", wr_ready); end
    tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midclr_no_resume: got %b expected 0", busy); end
  endtask

  initial begin
    test_reset();
    test_wrap();
    test_clear();
`ifdef LCD_TEXTBUF_DOUBLE_EN
    test_double();
    test_deferred();
`else
    test_single();
`endif
    test_reset_mid_clear();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
